down_timer: RTL and testbench
=============================

// Module: down_timer
// PURPOSE
//  Synchronous programmable down-counter/timer. Complements the ripple up-counter
//  by counting the other direction: it loads a start value and decrements to zero,
//  then flags terminal count. It serves as the interval/timeout source for
//  counter-based blocks, in one-shot or auto-reload (periodic) mode.
// PARAMETERS
//  WIDTH  4  counter and load-value width in bits (>=2)
// PORTS
//  clk       in   1      single clock; all state changes on rising edge
//  rst       in   1      synchronous, active-high reset
//  load      in   1      capture load_val into q and reload register; stops timer
//  load_val  in   WIDTH  value captured on load
//  start     in   1      begin counting from current q (ignored unless IDLE)
//  stop      in   1      abort counting; q holds its value
//  en        in   1      count enable (tick qualifier); low = pause in RUN
//  mode      in   1      0 = one-shot, 1 = auto-reload; latched on accepted start
//  q         out  WIDTH  current count
//  busy      out  1      1 while in RUN
//  tc        out  1      terminal-count strobe, one cycle, registered
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: q=0, reload_reg=0, mode_r=0, state=IDLE, busy=0, tc=0.
//  Priority per edge: rst > load > stop > start > count.
//  States: IDLE, RUN. busy == (state==RUN). All outputs registered.
//  IDLE:
//   - load: q<=load_val, reload_reg<=load_val, stay IDLE.
//   - start with q!=0: mode_r<=mode, ->RUN. Counting begins the next edge.
//   - start with q==0: ignored, stay IDLE, no tc.
//  RUN:
//   - load: q<=load_val, reload_reg<=load_val, ->IDLE. tc=0 that cycle.
//   - stop: ->IDLE, q unchanged, tc=0.
//   - en=0: q holds, tc=0.
//   - en=1 and q>1: q<=q-1.
//   - en=1 and q==1: q<=0, tc<=1.
//     - mode_r=0: ->IDLE, so busy falls on the same edge tc rises.
//     - mode_r=1: stay RUN.
//   - en=1 and q==0 (auto-reload only): q<=reload_reg. No tc.
//  Timing:
//   - Latency from start to the first decrement is 1 edge.
//   - One-shot: N enabled ticks from q=N give tc.
//   - Auto-reload period is reload_reg+1 enabled ticks. This includes the 0->reload tick.
//  Other rules:
//   - tc is high for exactly one cycle. It is never high in IDLE except on the cycle
//     after the final one-shot decrement.
//   - Arithmetic is unsigned modulo 2^WIDTH. q never underflows: the 0 state is
//     handled explicitly. Max load (2^WIDTH-1) is valid.
//   - mode changes during RUN are ignored until the next start.
//   - A start that arrives together with a load: load wins and start is dropped.
//   - A reset mid-count forces reset values on that edge with no tc.
// TESTING
//  1 rst=1 for 2 cycles -> q=0, busy=0, tc=0; start with q=0 -> stays IDLE, busy=0.
//  2 load 5, mode=0, start, en=1 -> q=5,4,3,2,1,0 on successive edges.
//    tc=1 only on the q=0 cycle; busy 1->0 on that same edge.
//  3 load 3, mode=1, start, en=1 -> q=3,2,1,0,3,2,1,0...
//    tc pulses once every 4 cycles; busy stays 1.
//  4 load 4, start, en pattern 1,0,0,1,1,1 -> q=3,3,3,2,1,0; tc only on the final 0.
//  5 load 9 (WIDTH=4), start, after q=6 assert load with load_val=2
//    -> q=2, busy=0, tc=0; then stop/start resumes 2,1,0.
//  6 mid-run at q=3: stop -> q holds at 3, busy=0. Then rst -> q=0.
//    Then load 15 (max), start -> tc after 15 ticks.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: synchronous programmable down-counter/timer.
// Loads a start value, decrements to zero on enabled ticks and flags terminal
// count. One-shot mode returns to IDLE at terminal count; auto-reload mode
// restores the reload value on the tick after reaching zero.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   load      capture load_val into q and the reload register; stops the timer
//   load_val  value captured on load
//   start     begin counting from current q (only honoured in IDLE, q != 0)
//   stop      abort counting, q holds
//   en        tick qualifier while running
//   mode      0 = one-shot, 1 = auto-reload; latched on an accepted start
//   q         current count
//   busy      high while running
//   tc        one-cycle registered terminal-count strobe
module down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic             mode_r, mode_n;
  logic             tc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      mode_r     <= 1'b0;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      reload_reg <= reload_n;
      mode_r     <= mode_n;
      tc         <= tc_n;
    end
  end

  // Priority: load > stop > start > count. tc defaults low so it can only
  // be a single-cycle strobe.
  always_comb begin
    state_n  = state;
    q_n      = q;
    reload_n = reload_reg;
    mode_n   = mode_r;
    tc_n     = 1'b0;

    if (load) begin
      q_n      = load_val;
      reload_n = load_val;
      state_n  = IDLE;
    end else if (stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (q != '0)) begin
            mode_n  = mode;
            state_n = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (q > WIDTH'(1)) begin
              q_n = q - WIDTH'(1);
            end else if (q == WIDTH'(1)) begin
              q_n  = '0;
              tc_n = 1'b1;
              if (!mode_r) state_n = IDLE;
            end else begin
              // q == 0 is only reachable in RUN with auto-reload; the
              // one-shot branch is a safe exit should it ever occur.
              if (mode_r) q_n = reload_reg;
              else        state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       en;
  logic       mode;
  logic [3:0] q;
  logic       busy;
  logic       tc;

  int checks;
  int failures;

  down_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .mode     (mode),
    .q        (q),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1; mode = m;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_load(4'd7);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
    en = 1'b1;
    do_start(1'b0);
    checks++;
    if (busy !== 1'b0 || q !== 4'd0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL start_q0 got busy=%b q=%0d tc=%b exp busy=0 q=0 tc=0", busy, q, tc);
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_q;
    do_load(4'd5);
    checks++;
    if (q !== 4'd5 || busy !== 1'b0) begin
      failures++; $display("FAIL oneshot_load got q=%0d busy=%b exp q=5 busy=0", q, busy);
    end
    en = 1'b1;
    do_start(1'b0);
    checks++;
    if (q !== 4'd5 || busy !== 1'b1 || tc !== 1'b0) begin
      failures++; $display("FAIL oneshot_start got q=%0d busy=%b tc=%b exp q=5 busy=1 tc=0", q, busy, tc);
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      exp_q = 4'(i);
      checks++;
      if (q !== exp_q || tc !== (i == 0) || busy !== (i != 0)) begin
        failures++;
        $display("FAIL oneshot_step got q=%0d tc=%b busy=%b exp q=%0d tc=%b busy=%b",
                 q, tc, busy, exp_q, (i == 0), (i != 0));
      end
    end
    tick();
    checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL oneshot_after got q=%0d tc=%b busy=%b exp q=0 tc=0 busy=0", q, tc, busy);
    end
  endtask

  task automatic test_reload();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    do_load(4'd3);
    en = 1'b1;
    do_start(1'b1);
    checks++;
    if (q !== 4'd3 || busy !== 1'b1) begin
      failures++; $display("FAIL reload_start got q=%0d busy=%b exp q=3 busy=1", q, busy);
    end
    // Changing mode mid-run must not turn this into a one-shot.
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (q !== exp_seq[i] || tc !== (exp_seq[i] == 4'd0) || busy !== 1'b1) begin
        failures++;
        $display("FAIL reload_step%0d got q=%0d tc=%b busy=%b exp q=%0d tc=%b busy=1",
                 i, q, tc, busy, exp_seq[i], (exp_seq[i] == 4'd0));
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || q !== 4'd3) begin
      failures++; $display("FAIL reload_stop got q=%0d busy=%b exp q=3 busy=0", q, busy);
    end
  endtask

  task automatic test_en_pause();
    logic       en_pat  [6];
    logic [3:0] exp_q   [6];
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_q  = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    do_load(4'd4);
    do_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      en = en_pat[i];
      tick();
      checks++;
      if (q !== exp_q[i] || tc !== (i == 5) || busy !== (i != 5)) begin
        failures++;
        $display("FAIL pause_step%0d got q=%0d tc=%b busy=%b exp q=%0d tc=%b busy=%b",
                 i, q, tc, busy, exp_q[i], (i == 5), (i != 5));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_load_abort();
    do_load(4'd9);
    do_start(1'b0);
    tick(); tick(); tick();
    checks++;
    if (q !== 4'd6) begin failures++; $display("FAIL abort_pre got q=%0d exp=6", q); end
    do_load(4'd2);
    checks++;
    if (q !== 4'd2 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++; $display("FAIL abort_load got q=%0d busy=%b tc=%b exp q=2 busy=0 tc=0", q, busy, tc);
    end
    do_start(1'b0);
    checks++;
    if (busy !== 1'b1 || q !== 4'd2) begin
      failures++; $display("FAIL abort_restart got q=%0d busy=%b exp q=2 busy=1", q, busy);
    end
    tick();
    checks++;
    if (q !== 4'd1 || tc !== 1'b0) begin failures++; $display("FAIL abort_q1 got q=%0d tc=%b exp q=1 tc=0", q, tc); end
    tick();
    checks++;
    if (q !== 4'd0 || tc !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_q0 got q=%0d tc=%b busy=%b exp q=0 tc=1 busy=0", q, tc, busy);
    end
  endtask

  task automatic test_back_to_back();
    // Simultaneous load and start: load wins, start is dropped.
    load = 1'b1; load_val = 4'd6; start = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    checks++;
    if (q !== 4'd6 || busy !== 1'b0) begin
      failures++; $display("FAIL load_start got q=%0d busy=%b exp q=6 busy=0", q, busy);
    end
    // Reset on the edge that would otherwise raise tc.
    do_load(4'd2);
    do_start(1'b0);
    tick();
    checks++;
    if (q !== 4'd1) begin failures++; $display("FAIL rst_mid_pre got q=%0d exp=1", q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid got q=%0d tc=%b busy=%b exp q=0 tc=0 busy=0", q, tc, busy);
    end
  endtask

  task automatic test_stop_max();
    int tc_seen;
    do_load(4'd5);
    do_start(1'b0);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (q !== 4'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL stop_hold got q=%0d busy=%b exp q=3 busy=0", q, busy);
    end
    tick();
    checks++;
    if (q !== 4'd3) begin failures++; $display("FAIL stop_idle got q=%0d exp=3", q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (q !== 4'd0) begin failures++; $display("FAIL stop_rst got q=%0d exp=0", q); end
    do_load(4'd15);
    do_start(1'b0);
    tc_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (tc === 1'b1) tc_seen = i;
    end
    checks++;
    if (tc_seen != 15 || q !== 4'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL max_load got tc_tick=%0d q=%0d busy=%b exp tc_tick=15 q=0 busy=0", tc_seen, q, busy);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
    stop = 1'b0; en = 1'b0; mode = 1'b0;
    tick();
    test_reset();
    test_oneshot();
    test_reload();
    test_en_pause();
    test_load_abort();
    test_back_to_back();
    test_stop_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
